// File: rtl/ltc2308_spi_model.sv
// ltc2308_spi_model: LTC2308 ADC serial-interface responder with emulated conversion time and parallel sample input.
module ltc2308_spi_model #(
  parameter int CONV_CYCLES = 64,
  parameter logic [5:0] RESET_CFG = 6'h22
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        CONVST,
  input  logic        SCK,
  input  logic        SDI,
  output logic        SDO,
  input  logic [11:0] sample_data,
  output logic        sample_req,
  output logic [2:0]  sel_ch,
  output logic        busy,
  output logic [5:0]  cfg_word,
  output logic        cfg_valid
);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CONVERT, ACQ} state_t;
  state_t state, state_d;
  logic [2:0] cs_sync, sck_sync;
  logic [1:0] sdi_sync;
  logic [CW-1:0] cnt, cnt_d;
  logic [11:0] data_sr, data_d;
  logic [4:0] cfg_sr, cfg_sr_d;
  logic [2:0] cfg_cnt, cfg_cnt_d, sel_ch_d;
  logic [5:0] cfg_word_d;
  logic sdo_d, busy_d, sample_req_d, cfg_valid_d;
  logic cs_rise, sck_rise, sck_fall, sdi;
  assign cs_rise = cs_sync[1] & ~cs_sync[2];
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign sdi = sdi_sync[1];
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
      state <= IDLE;
      cnt <= '0;
      data_sr <= '0;
      cfg_sr <= '0;
      cfg_cnt <= '0;
      cfg_word <= RESET_CFG;
      sel_ch <= '0;
      SDO <= 1'b0;
      busy <= 1'b0;
      sample_req <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[1:0], CONVST};
      sck_sync <= {sck_sync[1:0], SCK};
      sdi_sync <= {sdi_sync[0], SDI};
      state <= state_d;
      cnt <= cnt_d;
      data_sr <= data_d;
      cfg_sr <= cfg_sr_d;
      cfg_cnt <= cfg_cnt_d;
      cfg_word <= cfg_word_d;
      sel_ch <= sel_ch_d;
      SDO <= sdo_d;
      busy <= busy_d;
      sample_req <= sample_req_d;
      cfg_valid <= cfg_valid_d;
    end
  end
  // data_sr holds the remaining result bits MSB-aligned; zeros shift in so late falls drive 0
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    data_d = data_sr;
    cfg_sr_d = cfg_sr;
    cfg_cnt_d = cfg_cnt;
    cfg_word_d = cfg_word;
    sel_ch_d = sel_ch;
    sdo_d = SDO;
    busy_d = busy;
    sample_req_d = 1'b0;
    cfg_valid_d = 1'b0;
    if (state != CONVERT && cs_rise) begin
      sample_req_d = 1'b1;
      sel_ch_d = {cfg_word[3:2], cfg_word[4]};
      data_d = cfg_word[1] ? sample_data : sample_data ^ 12'h800;
      cnt_d = CW'(CONV_CYCLES - 1);
      busy_d = 1'b1;
      sdo_d = 1'b0;
      cfg_cnt_d = '0;
      state_d = CONVERT;
    end else if (state == CONVERT) begin
      if (cnt == '0) begin
        busy_d = 1'b0;
        sdo_d = data_sr[11];
        data_d = {data_sr[10:0], 1'b0};
        cfg_cnt_d = '0;
        state_d = ACQ;
      end else begin
        cnt_d = cnt - 1'b1;
      end
    end else if (state == ACQ) begin
      if (sck_rise && cfg_cnt < 3'd6) begin
        cfg_sr_d = {cfg_sr[3:0], sdi};
        cfg_cnt_d = cfg_cnt + 3'd1;
        if (cfg_cnt == 3'd5) begin
          cfg_word_d = {cfg_sr, sdi};
          cfg_valid_d = 1'b1;
        end
      end
      if (sck_fall) begin
        sdo_d = data_sr[11];
        data_d = {data_sr[10:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_ltc2308_spi_model.sv
// tb_ltc2308_spi_model: randomized and directed bench for ltc2308_spi_model against a behavioural ADC model.
module tb_ltc2308_spi_model;
  logic clock = 1'b0, reset = 1'b1, CONVST = 1'b0, SCK = 1'b0, SDI = 1'b0;
  logic SDO, sample_req, busy, cfg_valid;
  logic [11:0] sample_data = '0;
  logic [2:0] sel_ch;
  logic [5:0] cfg_word;
  int total = 0, bad = 0;
  logic [5:0] m_cfg = 6'h22;
  logic [11:0] m_res = '0;

  ltc2308_spi_model dut (
    .clock(clock), .reset(reset), .CONVST(CONVST), .SCK(SCK), .SDI(SDI), .SDO(SDO),
    .sample_data(sample_data), .sample_req(sample_req), .sel_ch(sel_ch), .busy(busy),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic convert(input logic [11:0] d, input bit glitch);
    int lat, busy_n, req_n;
    logic [2:0] exp_sel;
    exp_sel = {m_cfg[3:2], m_cfg[4]};
    m_res = m_cfg[1] ? d : 12'(d + 12'h800);
    sample_data = d;
    CONVST = 1'b1;
    lat = 0;
    while (!sample_req && lat < 10) begin
      tick();
      lat++;
    end
    check("req_lat", lat, 3);
    check("sel_ch", sel_ch, exp_sel);
    check("busy_start", busy, 1);
    check("sdo_start", SDO, 0);
    busy_n = 0;
    req_n = 0;
    while (busy && busy_n < 200) begin
      busy_n++;
      req_n += int'(sample_req);
      if (busy_n == 5) CONVST = 1'b0;
      if (glitch && busy_n == 15) begin
        CONVST = 1'b1;
        sample_data = ~d;
      end
      if (busy_n == 25) CONVST = 1'b0;
      tick();
    end
    CONVST = 1'b0;
    check("busy_len", busy_n, 64);
    check("req_cnt", req_n, 1);
    check("sdo_msb", SDO, m_res[11]);
    check("cfg_hold", cfg_word, m_cfg);
  endtask

  task automatic frame(input logic [5:0] cfg, input int n_pulse);
    int cv_at;
    for (int k = 1; k <= n_pulse; k++) begin
      SDI = (k <= 6) ? cfg[6-k] : 1'($urandom);
      tick();
      tick();
      SCK = 1'b1;
      cv_at = 0;
      for (int t = 1; t <= 4; t++) begin
        tick();
        if (cfg_valid) cv_at = (cv_at == 0) ? t : 99;
      end
      check("cfg_valid_at", cv_at, (k == 6) ? 3 : 0);
      SCK = 1'b0;
      for (int t = 0; t < 4; t++) tick();
      check("sdo_bit", SDO, (k < 12) ? 32'((m_res >> (11 - k)) & 12'd1) : 0);
    end
    if (n_pulse >= 6) m_cfg = cfg;
    check("cfg_word", cfg_word, m_cfg);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick();
    check("rst_busy", busy, 0);
    check("rst_sdo", SDO, 0);
    check("rst_cfg", cfg_word, 6'h22);
    check("rst_sel", sel_ch, 0);
    check("rst_req", sample_req, 0);
    check("rst_cv", cfg_valid, 0);
    reset = 1'b0;
    tick();
    convert(12'h801, 0);
    frame(6'h32, 14);
    convert(12'h5a5, 0);
    check("sel_after_32", sel_ch, 1);
    frame(6'h20, 14);
    convert(12'h911, 0);
    check("res_signed", m_res, 12'h111);
    frame(6'h26, 14);
    convert(12'h3c7, 1);
    frame(6'h15, 3);
    convert(12'h0f0, 0);
    frame(6'h32, 14);
    sample_data = 12'habc;
    CONVST = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    CONVST = 1'b0;
    check("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_sdo", SDO, 0);
    check("abort_cfg", cfg_word, 6'h22);
    check("abort_sel", sel_ch, 0);
    reset = 1'b0;
    m_cfg = 6'h22;
    tick();
    convert(12'h7ff, 0);
    frame(6'h2a, 13);
    for (int it = 0; it < 6; it++) begin
      convert(12'($urandom), bit'($urandom_range(0, 1)));
      frame(6'($urandom), (it == 2) ? 4 : 14);
    end
    convert(12'($urandom), 0);
    frame(6'h22, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
